// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared types and constants for the UART program loader.
//   loader_state_t : loader FSM states
//   BYTE_WIDTH     : width of one UART byte
//   LEN_WIDTH      : width of the frame word-count header
package program_loader_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int LEN_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    DATA,
    RUN,
    DONE
  } loader_state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler
// Collects little-endian bytes into DATA_WIDTH-bit words.
// Ports:
//   clk, arst   : clock, asynchronous active-high reset
//   clr         : synchronous restart of the byte count (start of a frame)
//   byte_valid  : byte_in is valid this cycle
//   byte_in     : incoming byte
//   word_valid  : registered one-cycle pulse, word holds a complete word
//   word        : assembled word (first byte received in bits [7:0])
module byte_word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  clr,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]            word_q, word_d;
  logic                             word_valid_q, word_valid_d;
  logic [DATA_WIDTH+BYTE_WIDTH-1:0] shifted;

  // New bytes enter at the top and move down, so after BYTES bytes the
  // first one received sits in bits [7:0].
  assign shifted = {byte_in, word_q} >> BYTE_WIDTH;

  always_comb begin
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (byte_valid) begin
      word_d = shifted[DATA_WIDTH-1:0];
      if (cnt_q == CNT_W'(BYTES - 1)) begin
        cnt_d        = '0;
        word_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader
// Receives a length-framed byte stream from the UART, writes the words into
// instruction memory in order, then hands control to the program counter.
// Ports:
//   clk, arst            : clock, asynchronous active-high reset
//   rx_data, rx_valid    : byte stream from the UART receiver
//   prog_ack             : program counter reports program end
//   imem_we/addr/wdata   : instruction memory write port (one pulse per word)
//   prog_ready           : program loaded, PC may advance
//   load_busy            : frame header or data being received
//   load_err             : sticky error (bad length or timeout)
//   run_done             : program end seen
module uart_program_loader
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  prog_ack,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  prog_ready,
  output logic                  load_busy,
  output logic                  load_err,
  output logic                  run_done
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;
  localparam int          TO_W      = $clog2(TIMEOUT_CYCLES);

  loader_state_t         state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [ADDR_WIDTH-1:0] word_last_q, word_last_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  prog_ready_q, prog_ready_d;
  logic                  load_busy_q, load_busy_d;
  logic                  load_err_q, load_err_d;
  logic                  run_done_q, run_done_d;

  logic                  asm_clr, asm_byte_valid, asm_word_valid;
  logic [DATA_WIDTH-1:0] asm_word;
  logic [LEN_WIDTH-1:0]  len_word;
  logic                  loading, timed_out;

  byte_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk        (clk),
    .arst       (arst),
    .clr        (asm_clr),
    .byte_valid (asm_byte_valid),
    .byte_in    (rx_data),
    .word_valid (asm_word_valid),
    .word       (asm_word)
  );

  assign len_word  = {rx_data, len_lo_q};
  assign loading   = (state_q == LEN_HI) || (state_q == DATA);
  assign timed_out = loading && !rx_valid && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d        = state_q;
    len_lo_d       = len_lo_q;
    word_last_d    = word_last_q;
    word_idx_d     = word_idx_q;
    load_err_d     = load_err_q;
    asm_clr        = 1'b0;
    asm_byte_valid = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (rx_valid) begin
          len_lo_d   = rx_data;
          load_err_d = 1'b0;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          if (len_word == '0 || 32'(len_word) > MAX_WORDS) begin
            load_err_d = 1'b1;
            state_d    = IDLE;
          end else begin
            // Store N-1 so the last-word test is a plain compare.
            word_last_d = ADDR_WIDTH'(len_word - LEN_WIDTH'(1));
            word_idx_d  = '0;
            asm_clr     = 1'b1;
            state_d     = DATA;
          end
        end else if (timed_out) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end
      end
      DATA: begin
        asm_byte_valid = rx_valid;
        // A word pulse always follows a byte, so it cannot coincide with
        // an expired timeout.
        if (asm_word_valid) begin
          word_idx_d = word_idx_q + ADDR_WIDTH'(1);
          if (word_idx_q == word_last_q) begin
            state_d = RUN;
          end
        end else if (timed_out) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end
      end
      RUN: begin
        if (prog_ack) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    to_cnt_d = (loading && !rx_valid && !timed_out) ? to_cnt_q + TO_W'(1) : '0;

    // Level outputs are registered copies of the next state.
    prog_ready_d = (state_d == RUN);
    load_busy_d  = (state_d == LEN_HI) || (state_d == DATA);
    run_done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      word_last_q  <= '0;
      word_idx_q   <= '0;
      to_cnt_q     <= '0;
      prog_ready_q <= 1'b0;
      load_busy_q  <= 1'b0;
      load_err_q   <= 1'b0;
      run_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      word_last_q  <= word_last_d;
      word_idx_q   <= word_idx_d;
      to_cnt_q     <= to_cnt_d;
      prog_ready_q <= prog_ready_d;
      load_busy_q  <= load_busy_d;
      load_err_q   <= load_err_d;
      run_done_q   <= run_done_d;
    end
  end

  // The write port comes straight from the assembler's registers; the
  // word index register is still pointing at the slot being written.
  assign imem_we    = asm_word_valid;
  assign imem_wdata = asm_word;
  assign imem_addr  = word_idx_q;
  assign prog_ready = prog_ready_q;
  assign load_busy  = load_busy_q;
  assign load_err   = load_err_q;
  assign run_done   = run_done_q;

endmodule
